// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//    Shares one single-port registered RAM between the CPU memory stage and a
//    camera pixel-write stream. Camera writes are buffered in a small
//    {addr,data} FIFO and drained whenever the CPU is idle. They are also
//    drained when the FIFO is full, or when the head entry has waited
//    STARVE_LIMIT cycles.
//
// Ports
//    clk, reset              clock, synchronous active-high reset
//    cpu_req/we/addr/wdata   CPU access request (stalled via cpu_stall)
//    cpu_rdata, cpu_rvalid   load return, one cycle after the load grant
//    cpu_stall               CPU request not granted this cycle
//    cam_valid/addr/data     camera write offer, accepted with cam_ready
//    cam_ready               FIFO has room (low during reset)
//    ram_addr/wdata/we       RAM command for the granted requester
//    ram_q                   RAM read data (one cycle after address)
module dmem_arbiter #(
   parameter int unsigned FIFO_DEPTH   = 4,
   parameter int unsigned STARVE_LIMIT = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic [31:0] cpu_rdata,
   output logic        cpu_rvalid,
   output logic        cpu_stall,
   input  logic        cam_valid,
   output logic        cam_ready,
   input  logic [31:0] cam_addr,
   input  logic [31:0] cam_data,
   output logic [31:0] ram_addr,
   output logic [31:0] ram_wdata,
   output logic        ram_we,
   input  logic [31:0] ram_q
);

   localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

   typedef enum logic [1:0] {
      GNT_NONE,
      GNT_CPU_RD,
      GNT_CPU_WR,
      GNT_CAM
   } gnt_e;

   logic [31:0]   fifo_addr_q [FIFO_DEPTH];
   logic [31:0]   fifo_data_q [FIFO_DEPTH];
   logic [PW-1:0] wptr_q, wptr_d;
   logic [PW-1:0] rptr_q, rptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [SW-1:0] starve_q, starve_d;
   logic [31:0]   addr_hold_q, addr_hold_d;
   logic [31:0]   wdata_hold_q, wdata_hold_d;
   logic [31:0]   rdata_q, rdata_d;
   gnt_e          last_gnt_q;
   gnt_e          gnt;

   logic full, empty, push, pop;

   assign full      = (count_q == CW'(FIFO_DEPTH));
   assign empty     = (count_q == '0);
   assign cam_ready = !full && !reset;
   assign push      = cam_valid && cam_ready;
   assign pop       = (gnt == GNT_CAM);

   // Grant: camera wins when it has data and the CPU is idle, the FIFO is
   // full, or the head has waited its limit; otherwise the CPU.
   always_comb begin
      gnt = GNT_NONE;
      if (!reset) begin
         if (!empty && (starve_q == SW'(STARVE_LIMIT) || full || !cpu_req))
            gnt = GNT_CAM;
         else if (cpu_req)
            gnt = cpu_we ? GNT_CPU_WR : GNT_CPU_RD;
      end
   end

   // RAM command is combinational so stores land on the grant edge; with no
   // grant the last address/data are replayed from the hold registers.
   always_comb begin
      ram_addr  = reset ? '0 : addr_hold_q;
      ram_wdata = reset ? '0 : wdata_hold_q;
      ram_we    = 1'b0;
      case (gnt)
         GNT_CAM: begin
            ram_addr  = fifo_addr_q[rptr_q];
            ram_wdata = fifo_data_q[rptr_q];
            ram_we    = 1'b1;
         end
         GNT_CPU_RD, GNT_CPU_WR: begin
            ram_addr  = cpu_addr;
            ram_wdata = cpu_wdata;
            ram_we    = cpu_we;
         end
         default: ;
      endcase
   end

   assign cpu_stall  = cpu_req && !reset && (gnt != GNT_CPU_RD) && (gnt != GNT_CPU_WR);
   assign cpu_rvalid = !reset && (last_gnt_q == GNT_CPU_RD);
   assign cpu_rdata  = reset ? '0 : (cpu_rvalid ? ram_q : rdata_q);

   always_comb begin
      wptr_d       = push ? wptr_q + PW'(1) : wptr_q;
      rptr_d       = pop  ? rptr_q + PW'(1) : rptr_q;
      count_d      = count_q;
      if (push && !pop)
         count_d = count_q + CW'(1);
      else if (pop && !push)
         count_d = count_q - CW'(1);
      starve_d     = starve_q;
      if (empty || pop)
         starve_d = '0;
      else if (starve_q != SW'(STARVE_LIMIT))
         starve_d = starve_q + SW'(1);
      addr_hold_d  = ram_addr;
      wdata_hold_d = ram_wdata;
      rdata_d      = cpu_rdata;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wptr_q       <= '0;
         rptr_q       <= '0;
         count_q      <= '0;
         starve_q     <= '0;
         addr_hold_q  <= '0;
         wdata_hold_q <= '0;
         rdata_q      <= '0;
         last_gnt_q   <= GNT_NONE;
      end else begin
         wptr_q       <= wptr_d;
         rptr_q       <= rptr_d;
         count_q      <= count_d;
         starve_q     <= starve_d;
         addr_hold_q  <= addr_hold_d;
         wdata_hold_q <= wdata_hold_d;
         rdata_q      <= rdata_d;
         last_gnt_q   <= gnt;
      end
   end

   // FIFO storage needs no reset; the pointers and count define validity.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr_q[wptr_q] <= cam_addr;
         fifo_data_q[wptr_q] <= cam_data;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: registered RAM model, write/load scoreboards
// and one task per scenario.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_req, cpu_we;
   logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic        cpu_rvalid, cpu_stall;
   logic        cam_valid, cam_ready;
   logic [31:0] cam_addr, cam_data;
   logic [31:0] ram_addr, ram_wdata;
   logic        ram_we;
   logic [31:0] ram_q;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
   } wr_t;

   wr_t         exp_wr[$];
   logic [31:0] exp_rd[$];
   wr_t         mon_w;
   logic [31:0] mon_r;

   logic [31:0] mem [0:1023];

   always #5 clk = ~clk;

   dmem_arbiter #(.FIFO_DEPTH(4), .STARVE_LIMIT(8)) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid), .cpu_stall(cpu_stall),
      .cam_valid(cam_valid), .cam_ready(cam_ready), .cam_addr(cam_addr), .cam_data(cam_data),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_q(ram_q)
   );

   // Registered single-port RAM environment
   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = '0;
      ram_q = '0;
   end

   always @(posedge clk) begin
      ram_q <= mem[ram_addr[9:0]];
      if (ram_we === 1'b1) mem[ram_addr[9:0]] <= ram_wdata;
   end

   // Scoreboard: every RAM write and every load return is matched in order
   always @(negedge clk) begin
      #2;
      if (ram_we === 1'b1) begin
         total++;
         if (exp_wr.size() == 0) begin
            bad++;
            $display("FAIL sb_write: got unexpected write addr=%h data=%h, required no write", ram_addr, ram_wdata);
         end else begin
            mon_w = exp_wr.pop_front();
            if (ram_addr !== mon_w.a || ram_wdata !== mon_w.d) begin
               bad++;
               $display("FAIL sb_write: got addr=%h data=%h, required addr=%h data=%h",
                        ram_addr, ram_wdata, mon_w.a, mon_w.d);
            end
         end
      end
      if (cpu_rvalid === 1'b1) begin
         total++;
         if (exp_rd.size() == 0) begin
            bad++;
            $display("FAIL sb_load: got unexpected rvalid data=%h, required none", cpu_rdata);
         end else begin
            mon_r = exp_rd.pop_front();
            if (cpu_rdata !== mon_r) begin
               bad++;
               $display("FAIL sb_load: got %h, required %h", cpu_rdata, mon_r);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "timeout");
   end

   task automatic idle_inputs();
      cpu_req   = 1'b0;
      cpu_we    = 1'b0;
      cpu_addr  = '0;
      cpu_wdata = '0;
      cam_valid = 1'b0;
      cam_addr  = '0;
      cam_data  = '0;
   endtask

   task automatic drain_and_check_queues(input string name);
      @(negedge clk);
      idle_inputs();
      #3;
      total++;
      if (exp_wr.size() != 0 || exp_rd.size() != 0) begin
         bad++;
         $display("FAIL %s_pending: got wr=%0d rd=%0d outstanding, required 0 0",
                  name, exp_wr.size(), exp_rd.size());
      end
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      cpu_req   = 1'b1;
      cpu_we    = 1'b1;
      cpu_addr  = 32'h55;
      cpu_wdata = 32'h66;
      cam_valid = 1'b1;
      cam_addr  = 32'h77;
      cam_data  = 32'h88;
      repeat (2) begin
         @(negedge clk);
         #1;
         total++;
         if ({ram_we, cpu_rvalid, cpu_stall, cam_ready} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_flags: got we/rv/stall/rdy=%b, required 0000",
                     {ram_we, cpu_rvalid, cpu_stall, cam_ready});
         end
         total++;
         if (ram_addr !== 32'h0 || ram_wdata !== 32'h0 || cpu_rdata !== 32'h0) begin
            bad++;
            $display("FAIL reset_data: got addr=%h wdata=%h rdata=%h, required all 0",
                     ram_addr, ram_wdata, cpu_rdata);
         end
      end
      @(negedge clk);
      reset = 1'b0;
      idle_inputs();
      #1;
      total++;
      if (cam_ready !== 1'b1 || ram_we !== 1'b0 || cpu_stall !== 1'b0) begin
         bad++;
         $display("FAIL reset_release: got rdy=%b we=%b stall=%b, required 1 0 0",
                  cam_ready, ram_we, cpu_stall);
      end
   endtask

   task automatic test_cpu_store_load();
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'h5;
      exp_wr.push_back('{a: 32'h10, d: 32'h5});
      #1;
      total++;
      if (cpu_stall !== 1'b0 || ram_we !== 1'b1) begin
         bad++;
         $display("FAIL store_grant: got stall=%b we=%b, required 0 1", cpu_stall, ram_we);
      end
      @(negedge clk);
      cpu_we = 1'b0; cpu_wdata = 32'h0;
      exp_rd.push_back(32'h5);
      #1;
      total++;
      if (cpu_stall !== 1'b0 || ram_we !== 1'b0 || ram_addr !== 32'h10) begin
         bad++;
         $display("FAIL load_grant: got stall=%b we=%b addr=%h, required 0 0 00000010",
                  cpu_stall, ram_we, ram_addr);
      end
      @(negedge clk);
      idle_inputs();
      #1;
      total++;
      if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h5 || cpu_stall !== 1'b0) begin
         bad++;
         $display("FAIL load_return: got rv=%b data=%h stall=%b, required 1 00000005 0",
                  cpu_rvalid, cpu_rdata, cpu_stall);
      end
      @(negedge clk);
      #1;
      total++;
      if (cpu_rvalid !== 1'b0 || cpu_rdata !== 32'h5) begin
         bad++;
         $display("FAIL load_hold: got rv=%b data=%h, required 0 00000005", cpu_rvalid, cpu_rdata);
      end
      drain_and_check_queues("store_load");
   endtask

   task automatic test_cam_only();
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         cpu_req   = 1'b0;
         cam_valid = (c < 4);
         cam_addr  = 32'h100 + c;
         cam_data  = 32'hCA00_0000 + c;
         if (c < 4) exp_wr.push_back('{a: 32'h100 + c, d: 32'hCA00_0000 + c});
         #1;
         if (c < 4) begin
            total++;
            if (cam_ready !== 1'b1) begin
               bad++;
               $display("FAIL cam_only_ready: cycle %0d got %b, required 1", c, cam_ready);
            end
         end
         total++;
         if (ram_we !== (c >= 1 && c <= 4)) begin
            bad++;
            $display("FAIL cam_only_we: cycle %0d got %b, required %b", c, ram_we, (c >= 1 && c <= 4));
         end
      end
      total++;
      if (dut.count_q !== 0) begin
         bad++;
         $display("FAIL cam_only_empty: got count=%0d, required 0", dut.count_q);
      end
      drain_and_check_queues("cam_only");
   endtask

   task automatic test_starve();
      logic exp_stall;
      for (int c = 0; c < 11; c++) begin
         @(negedge clk);
         cpu_req   = 1'b1;
         cpu_we    = 1'b0;
         cpu_addr  = 32'h10;
         cam_valid = (c == 0);
         cam_addr  = 32'h200;
         cam_data  = 32'hAAAA_0001;
         exp_stall = (c == 9);
         if (c == 0) exp_wr.push_back('{a: 32'h200, d: 32'hAAAA_0001});
         if (!exp_stall) exp_rd.push_back(32'h5);
         #1;
         total++;
         if (cpu_stall !== exp_stall || ram_we !== exp_stall) begin
            bad++;
            $display("FAIL starve_grant: cycle %0d got stall=%b we=%b, required %b %b",
                     c, cpu_stall, ram_we, exp_stall, exp_stall);
         end
         if (c == 10) begin
            total++;
            if (dut.starve_q !== 0) begin
               bad++;
               $display("FAIL starve_clear: got %0d, required 0", dut.starve_q);
            end
         end
      end
      drain_and_check_queues("starve");
   endtask

   task automatic test_full_drain();
      logic exp_cam;
      for (int c = 0; c < 34; c++) begin
         @(negedge clk);
         cpu_req   = 1'b1;
         cpu_we    = 1'b0;
         cpu_addr  = 32'h10;
         cam_valid = (c <= 4);
         cam_addr  = 32'h300 + c;
         cam_data  = 32'hBB00_0000 + c;
         exp_cam   = (c == 4 || c == 13 || c == 22 || c == 31);
         if (c < 4) exp_wr.push_back('{a: 32'h300 + c, d: 32'hBB00_0000 + c});
         if (!exp_cam) exp_rd.push_back(32'h5);
         #1;
         total++;
         if (cpu_stall !== exp_cam || ram_we !== exp_cam) begin
            bad++;
            $display("FAIL drain_grant: cycle %0d got stall=%b we=%b, required %b %b",
                     c, cpu_stall, ram_we, exp_cam, exp_cam);
         end
         if (c <= 5) begin
            total++;
            if (cam_ready !== (c != 4)) begin
               bad++;
               $display("FAIL drain_ready: cycle %0d got %b, required %b", c, cam_ready, (c != 4));
            end
         end
      end
      drain_and_check_queues("full_drain");
   endtask

   task automatic test_wrap();
      @(negedge clk);
      reset = 1'b1;
      idle_inputs();
      @(negedge clk);
      reset = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         cpu_req   = (c < 2);
         cpu_we    = 1'b0;
         cpu_addr  = 32'h10;
         cam_valid = (c < 5);
         cam_addr  = 32'h400 + c;
         cam_data  = 32'hD000_0000 + c;
         if (c < 5) exp_wr.push_back('{a: 32'h400 + c, d: 32'hD000_0000 + c});
         if (c < 2) exp_rd.push_back(32'h5);
         #1;
         total++;
         if (ram_we !== (c >= 2 && c <= 6)) begin
            bad++;
            $display("FAIL wrap_we: cycle %0d got %b, required %b", c, ram_we, (c >= 2 && c <= 6));
         end
         if (c >= 2 && c <= 5) begin
            total++;
            if (dut.count_q !== 2) begin
               bad++;
               $display("FAIL wrap_count: cycle %0d got %0d, required 2", c, dut.count_q);
            end
         end
         if (c == 4) begin
            total++;
            if (dut.wptr_q !== 0) begin
               bad++;
               $display("FAIL wrap_wptr: got %0d, required 0", dut.wptr_q);
            end
         end
      end
      drain_and_check_queues("wrap");
   endtask

   task automatic test_reset_mid();
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         cpu_req   = 1'b1;
         cpu_we    = 1'b0;
         cpu_addr  = 32'h10;
         cam_valid = 1'b1;
         cam_addr  = 32'h500 + c;
         cam_data  = 32'hE000_0000 + c;
         if (c < 2) exp_rd.push_back(32'h5);
      end
      @(negedge clk);
      reset     = 1'b1;
      cam_addr  = 32'h503;
      #1;
      total++;
      if ({ram_we, cpu_rvalid, cpu_stall, cam_ready} !== 4'b0000 ||
          ram_addr !== 32'h0 || ram_wdata !== 32'h0 || cpu_rdata !== 32'h0) begin
         bad++;
         $display("FAIL midreset_outputs: got we/rv/stall/rdy=%b addr=%h wdata=%h rdata=%h, required 0000 0 0 0",
                  {ram_we, cpu_rvalid, cpu_stall, cam_ready}, ram_addr, ram_wdata, cpu_rdata);
      end
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         reset = 1'b0;
         idle_inputs();
         #1;
         total++;
         if (ram_we !== 1'b0 || cpu_rvalid !== 1'b0 || cam_ready !== 1'b1 || cpu_rdata !== 32'h0) begin
            bad++;
            $display("FAIL midreset_after: cycle %0d got we=%b rv=%b rdy=%b rdata=%h, required 0 0 1 0",
                     c, ram_we, cpu_rvalid, cam_ready, cpu_rdata);
         end
      end
      total++;
      if (dut.count_q !== 0) begin
         bad++;
         $display("FAIL midreset_count: got %0d, required 0", dut.count_q);
      end
      drain_and_check_queues("reset_mid");
   endtask

   initial begin
      reset = 1'b1;
      idle_inputs();
      test_reset();
      test_cpu_store_load();
      test_cam_only();
      test_starve();
      test_full_drain();
      test_wrap();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
